// File: rtl/countdown_controller.sv
// countdown_controller
// Programmable down-counter advanced by a prescaled tick. Supports start,
// pause/resume, clear, one-shot and auto-reload operation. Single clock
// domain: the prescaler produces an enable, never a derived clock.
//
// Ports:
//   mainClock   : system clock, all logic on the rising edge
//   reset       : synchronous, active-high, highest priority
//   start       : begin from IDLE/DONE, resume from PAUSE (level-sampled)
//   stop        : pause request while running
//   clear       : abort to IDLE from any state
//   auto_reload : 1 = reload at terminal count and keep running, 0 = one-shot
//   load_value  : initial count, sampled on start and on auto-reload
//   div_limit   : tick period minus one, compared live
//   count       : current count (registered)
//   tick        : one-cycle pulse per prescaler expiry applied in RUN
//   done        : one-cycle pulse at terminal count
//   running     : high iff state is RUN
//   state       : IDLE=0, RUN=1, PAUSE=2, DONE=3
module countdown_controller #(
    parameter int unsigned CNT_WIDTH = 4,
    parameter int unsigned DIV_WIDTH = 24
) (
    input  logic                 mainClock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 clear,
    input  logic                 auto_reload,
    input  logic [CNT_WIDTH-1:0] load_value,
    input  logic [DIV_WIDTH-1:0] div_limit,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 tick,
    output logic                 done,
    output logic                 running,
    output logic [1:0]           state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e               state_q;
    state_e               state_d;
    logic [DIV_WIDTH-1:0] pre_q;
    logic [DIV_WIDTH-1:0] pre_d;
    logic [CNT_WIDTH-1:0] count_d;
    logic                 tick_d;
    logic                 done_d;
    logic                 expiry_c;

    // >= rather than == so a live decrease of div_limit below the current
    // prescaler value still expires instead of wrapping the prescaler.
    assign expiry_c = (pre_q >= div_limit);

    assign state = state_q;

    // State, count, prescaler and pulse registers.
    always_ff @(posedge mainClock) begin
        if (reset) begin
            state_q <= S_IDLE;
            count   <= '1;
            pre_q   <= '0;
            tick    <= 1'b0;
            done    <= 1'b0;
            running <= 1'b0;
        end else begin
            state_q <= state_d;
            count   <= count_d;
            pre_q   <= pre_d;
            tick    <= tick_d;
            done    <= done_d;
            running <= (state_d == S_RUN);
        end
    end

    // Next-state, next-count and pulse generation.
    always_comb begin
        state_d = state_q;
        count_d = count;
        pre_d   = pre_q;
        tick_d  = 1'b0;
        done_d  = 1'b0;

        if (clear) begin
            state_d = S_IDLE;
            count_d = '1;
            pre_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        count_d = load_value;
                        pre_d   = '0;
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    // A pause discards any same-cycle expiry; the held
                    // prescaler makes it recur on the first cycle after resume.
                    if (stop) begin
                        state_d = S_PAUSE;
                    end else if (expiry_c) begin
                        pre_d  = '0;
                        tick_d = 1'b1;
                        if (count != '0) begin
                            count_d = count - CNT_WIDTH'(1);
                        end else begin
                            done_d = 1'b1;
                            if (auto_reload) begin
                                count_d = load_value;
                            end else begin
                                state_d = S_DONE;
                            end
                        end
                    end else begin
                        pre_d = pre_q + DIV_WIDTH'(1);
                    end
                end
                S_PAUSE: begin
                    if (start && !stop) begin
                        state_d = S_RUN;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_countdown_controller.sv
// tb_countdown_controller
// Scoreboard bench: each applied input vector pushes the reference model's
// expected post-edge outputs into a queue; an independent monitor pops and
// compares one entry per clock edge.
module tb_countdown_controller;

    localparam int unsigned CNT_WIDTH = 4;
    localparam int unsigned DIV_WIDTH = 24;
    localparam int          CNT_MAX   = (1 << CNT_WIDTH) - 1;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic                 mainClock = 1'b0;
    logic                 reset;
    logic                 start;
    logic                 stop;
    logic                 clear;
    logic                 auto_reload;
    logic [CNT_WIDTH-1:0] load_value;
    logic [DIV_WIDTH-1:0] div_limit;
    logic [CNT_WIDTH-1:0] count;
    logic                 tick;
    logic                 done;
    logic                 running;
    logic [1:0]           state;

    countdown_controller #(
        .CNT_WIDTH (CNT_WIDTH),
        .DIV_WIDTH (DIV_WIDTH)
    ) dut (
        .mainClock   (mainClock),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .clear       (clear),
        .auto_reload (auto_reload),
        .load_value  (load_value),
        .div_limit   (div_limit),
        .count       (count),
        .tick        (tick),
        .done        (done),
        .running     (running),
        .state       (state)
    );

    always #5 mainClock = ~mainClock;

    typedef struct {
        int count;
        int state;
        bit tick;
        bit done;
        bit running;
        int ph;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    bit   stim_done   = 1'b0;
    int   phase       = 0;

    // Reference model: timer mode, remaining count, and cycles spent in RUN
    // since the last tick.
    int m_mode = M_IDLE;
    int m_cnt  = CNT_MAX;
    int m_elapsed = 0;

    task automatic model_step(input bit rst, input bit st, input bit sp,
                              input bit clr, input bit ar, input int lv,
                              input int dl, output exp_t e);
        e.tick = 1'b0;
        e.done = 1'b0;
        if (rst || clr) begin
            m_mode    = M_IDLE;
            m_cnt     = CNT_MAX;
            m_elapsed = 0;
        end else if (m_mode == M_RUN) begin
            if (sp) begin
                m_mode = M_PAUSE;
            end else if (m_elapsed >= dl) begin
                m_elapsed = 0;
                e.tick    = 1'b1;
                if (m_cnt > 0) begin
                    m_cnt = m_cnt - 1;
                end else begin
                    e.done = 1'b1;
                    if (ar) m_cnt = lv;
                    else    m_mode = M_DONE;
                end
            end else begin
                m_elapsed = m_elapsed + 1;
            end
        end else if (m_mode == M_PAUSE) begin
            if (st && !sp) m_mode = M_RUN;
        end else if (st) begin
            m_cnt     = lv;
            m_elapsed = 0;
            m_mode    = M_RUN;
        end
        e.count   = m_cnt;
        e.state   = m_mode;
        e.running = (m_mode == M_RUN);
        e.ph      = phase;
    endtask

    // Drive one cycle of inputs, record the expectation, wait for the next
    // falling edge (one rising edge in between).
    task automatic apply(input bit rst, input bit st, input bit sp,
                         input bit clr, input bit ar, input int lv, input int dl);
        exp_t e;
        reset       = rst;
        start       = st;
        stop        = sp;
        clear       = clr;
        auto_reload = ar;
        load_value  = CNT_WIDTH'(lv);
        div_limit   = DIV_WIDTH'(dl);
        model_step(rst, st, sp, clr, ar, lv, dl, e);
        exp_q.push_back(e);
        @(negedge mainClock);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge mainClock);
            #1;
            if (stim_done) break;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL no_expectation t=%0t: DUT output with empty queue", $time);
            end else begin
                e = exp_q.pop_front();
                if (count !== CNT_WIDTH'(e.count) || state !== 2'(e.state) ||
                    tick !== e.tick || done !== e.done || running !== e.running) begin
                    miscompares++;
                    $display("FAIL phase%0d t=%0t got/exp count=%0d/%0d state=%0d/%0d tick=%0b/%0b done=%0b/%0b running=%0b/%0b",
                             e.ph, $time, count, e.count, state, e.state,
                             tick, e.tick, done, e.done, running, e.running);
                end
            end
        end
    end

    initial begin : stimulus
        int lv;
        int dl;
        bit ar;

        // Reset, then idle
        phase = 1;
        apply(1, 0, 0, 0, 0, 0, 0);
        apply(1, 0, 0, 0, 0, 0, 0);
        repeat (5) apply(0, 0, 0, 0, 0, 0, 0);

        // One-shot run: div_limit=3, load_value=5
        phase = 2;
        apply(0, 1, 0, 0, 0, 5, 3);
        repeat (30) apply(0, 0, 0, 0, 0, 5, 3);

        // Same run paused on the cycle of the second expiry
        phase = 3;
        apply(0, 1, 0, 0, 0, 5, 3);
        repeat (7) apply(0, 0, 0, 0, 0, 5, 3);
        apply(0, 0, 1, 0, 0, 5, 3);
        repeat (10) apply(0, 0, 0, 0, 0, 5, 3);
        apply(0, 1, 0, 0, 0, 5, 3);
        repeat (40) apply(0, 0, 0, 0, 0, 5, 3);

        // Auto-reload with a tick every cycle
        phase = 4;
        apply(0, 1, 0, 0, 1, 2, 0);
        repeat (12) apply(0, 0, 0, 0, 1, 2, 0);

        // Clear mid-RUN with start and stop also high, then restart
        phase = 5;
        repeat (2) apply(0, 0, 0, 0, 0, 5, 3);
        apply(0, 1, 1, 1, 0, 5, 3);
        repeat (3) apply(0, 0, 0, 0, 0, 5, 3);
        apply(0, 1, 0, 0, 0, 5, 3);
        repeat (10) apply(0, 0, 0, 0, 0, 5, 3);

        // Reach DONE, then reset together with start
        phase = 6;
        apply(0, 0, 0, 1, 0, 1, 0);
        apply(0, 1, 0, 0, 0, 1, 0);
        repeat (4) apply(0, 0, 0, 0, 0, 1, 0);
        apply(1, 1, 0, 0, 0, 1, 0);
        repeat (2) apply(0, 0, 0, 0, 0, 1, 0);

        // Randomized traffic, including live div_limit changes
        phase = 7;
        dl = 2;
        ar = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            bit r;
            bit st;
            bit sp;
            bit clr;
            if ($urandom_range(0, 49) == 0) dl = int'($urandom_range(0, 6));
            if ($urandom_range(0, 99) == 0) ar = ~ar;
            lv  = int'($urandom_range(0, CNT_MAX));
            r   = ($urandom_range(0, 299) == 0);
            st  = ($urandom_range(0, 7) == 0);
            sp  = ($urandom_range(0, 11) == 0);
            clr = ($urandom_range(0, 79) == 0);
            apply(r, st, sp, clr, ar, lv, dl);
        end

        stim_done = 1'b1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        #30;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/countdown_controller.md
Name: countdown_controller

Overview:
- Sequences a programmable down-counter from a prescaled tick. Supports start, pause/resume, clear, one-shot and auto-reload modes.
- Replaces the free-running divider+counter pair with a controllable timer. Its outputs drive display and event logic.
- Single clock domain; the prescaler is an enable, never a derived clock.

Parameters:
- CNT_WIDTH, 4, width of count, load_value.
- DIV_WIDTH, 24, width of prescaler and div_limit.

Ports:
- mainClock  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high; highest priority
- start  input  1  level-sampled each cycle; begin/resume/restart
- stop  input  1  pause request while running
- clear  input  1  abort to IDLE
- auto_reload  input  1  1: reload at terminal count and keep running; 0: one-shot
- load_value  input  CNT_WIDTH  initial count, sampled on start from IDLE/DONE and on auto-reload
- div_limit  input  DIV_WIDTH  tick period minus 1, compared live
- count  output  CNT_WIDTH  current count, registered
- tick  output  1  registered; high one cycle per prescaler expiry applied in RUN
- done  output  1  registered one-cycle pulse at terminal count
- running  output  1  high iff state==RUN
- state  output  2  IDLE=0, RUN=1, PAUSE=2, DONE=3

Behaviour:
- Reset:
  - state=IDLE, count=all ones, prescaler=0.
  - tick=0, done=0, running=0.
- Priority each cycle: reset > clear > stop > start > internal tick.
- Prescaler:
  - Counts only in RUN.
  - Expiry when prescaler>=div_limit. The >= compare handles a live decrease of div_limit.
  - On expiry, prescaler<=0. Otherwise prescaler+1.
  - div_limit=0 gives a tick every RUN cycle. Tick period is div_limit+1 cycles.
- IDLE: start -> count<=load_value, prescaler<=0, RUN. count and running update the cycle after start is sampled.
- RUN, on expiry:
  - count!=0: count<=count-1, tick=1.
  - count==0: tick=1, done=1.
    - auto_reload=1: count<=load_value, stay RUN.
    - auto_reload=0: count stays 0, go to DONE.
- RUN, other inputs:
  - stop -> PAUSE. count and prescaler hold. A same-cycle expiry is discarded, with no tick and no decrement. The prescaler keeps its value, so expiry recurs on the first RUN cycle after resume.
  - start while RUN is ignored.
- PAUSE:
  - start and not stop -> RUN; prescaler continues from its held value.
  - start with stop -> stays PAUSE.
- DONE:
  - count=0, running=0.
  - start -> count<=load_value, prescaler<=0, RUN.
  - stop is ignored.
- clear, any state: state=IDLE, count=all ones, prescaler=0. tick and done are 0 the next cycle.
- load_value=0: the first expiry fires done immediately.
- Arithmetic:
  - Unsigned.
  - count never wraps below 0. Terminal is detected at 0 before decrementing.
  - Prescaler never exceeds its width because of the >= compare.
- tick and done each last exactly one cycle, never back-to-back unless div_limit=0.

Test Plan:
- Reset, then idle 5 cycles -> count=4'hF, state=0, running=0, tick=0, done=0.
- div_limit=3, load_value=5, auto_reload=0, 1-cycle start:
  - count=5 one cycle later.
  - Decrements every 4 cycles, with tick on each.
  - done pulses 24 cycles after RUN entry; state=3, count=0, running=0.
- Same setup, stop asserted on the cycle of the 2nd expiry:
  - count stays 4, state=2.
  - Hold 10 cycles, then start: count=3 on the next cycle.
  - Total done delayed by exactly the paused cycles.
- div_limit=0, load_value=2, auto_reload=1:
  - count cycles 2,1,0,2,1,0 one step per cycle.
  - done pulses every 3rd cycle; state stays 1.
- clear mid-RUN with start and stop also high -> next cycle state=0, count=4'hF, prescaler restarts from 0 on the next start.
- reset asserted together with start in DONE -> next cycle state=0, count=4'hF, done=0.
